// File: rtl/ysyx_22041211_dsram_resp.sv
// ysyx_22041211_dsram_resp: LSU data-memory responder with programmable latency over a word array.
// Define YSYX_22041211_DSRAM_RANGE_CHK_EN to flag out-of-range addresses via rsp_err instead of wrapping.
module ysyx_22041211_dsram_resp #(
  parameter int ADDR_LEN   = 32,
  parameter int DATA_LEN   = 32,
  parameter int DEPTH_LOG2 = 12,
  parameter int LATENCY    = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_wen,
  input  logic [ADDR_LEN-1:0] req_addr,
  input  logic [DATA_LEN-1:0] req_wdata,
  input  logic [7:0]          req_wmask,
  input  logic [7:0]          req_rmask,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_LEN-1:0] rsp_rdata,
  output logic                rsp_err
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic wen_q, oor_q, err_q;
  logic [1:0] off_q;
  logic [3:0] emask_q;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic [DATA_LEN-1:0] wdata_q, rdata_q;
  logic [DATA_LEN-1:0] mem_q [2**DEPTH_LOG2];
  logic accept, go_resp, in_oor, cur_wen, cur_oor;
  logic [1:0] cur_off;
  logic [3:0] in_emask, cur_emask;
  logic [DEPTH_LOG2-1:0] cur_idx;
  logic [DATA_LEN-1:0] in_wdata, cur_wdata, lanes, rd_word, rd_val;
  logic unused;
  assign unused = ^{req_wmask[7:4], req_rmask[7:4], req_addr};
  assign accept = (state_q == S_IDLE) && req_valid;
  assign in_emask = (req_wen ? req_wmask[3:0] : req_rmask[3:0]) << req_addr[1:0];
  assign in_wdata = req_wdata << {req_addr[1:0], 3'b000};
`ifdef YSYX_22041211_DSRAM_RANGE_CHK_EN
  assign in_oor = |req_addr[ADDR_LEN-1:DEPTH_LOG2+2];
`else
  assign in_oor = 1'b0;
`endif
  // With LATENCY==1 the commit happens on the accept edge, so use the live request fields.
  assign cur_wen   = accept ? req_wen : wen_q;
  assign cur_oor   = accept ? in_oor : oor_q;
  assign cur_off   = accept ? req_addr[1:0] : off_q;
  assign cur_emask = accept ? in_emask : emask_q;
  assign cur_idx   = accept ? req_addr[DEPTH_LOG2+1:2] : idx_q;
  assign cur_wdata = accept ? in_wdata : wdata_q;
  assign go_resp = (accept && LATENCY == 1) || (state_q == S_WAIT && cnt_q == 4'd0);
  assign lanes = {{8{cur_emask[3]}}, {8{cur_emask[2]}}, {8{cur_emask[1]}}, {8{cur_emask[0]}}};
  assign rd_word = mem_q[cur_idx];
  assign rd_val = (rd_word & lanes) >> {cur_off, 3'b000};
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    case (state_q)
      S_IDLE: if (req_valid) begin
        state_d = (LATENCY == 1) ? S_RESP : S_WAIT;
        cnt_d = 4'(LATENCY - 1);
      end
      S_WAIT: begin
        state_d = (cnt_q == 4'd0) ? S_RESP : S_WAIT;
        cnt_d = (cnt_q == 4'd0) ? cnt_q : cnt_q - 4'd1;
      end
      S_RESP: state_d = rsp_ready ? S_IDLE : S_RESP;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q <= 4'd0;
      wen_q <= 1'b0;
      oor_q <= 1'b0;
      off_q <= 2'd0;
      emask_q <= 4'd0;
      idx_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      if (accept) begin
        wen_q <= req_wen;
        oor_q <= in_oor;
        off_q <= req_addr[1:0];
        emask_q <= in_emask;
        idx_q <= req_addr[DEPTH_LOG2+1:2];
        wdata_q <= in_wdata;
      end
      if (go_resp) begin
        rdata_q <= (cur_wen || cur_oor) ? '0 : rd_val;
        err_q <= cur_oor;
      end
    end
  end
  // Storage is deliberately not reset; a store commits only on the edge entering RESP.
  always_ff @(posedge clk)
    if (!rst && go_resp && cur_wen && !cur_oor)
      mem_q[cur_idx] <= (rd_word & ~lanes) | (cur_wdata & lanes);
  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err = err_q;
endmodule
